code_writer: RTL and testbench

- Write-side counterpart of the lock's code-memory reader.
- Accepts a programming session of up to 16 bytes over a valid/ready stream into a staging buffer. On the final byte it commits the whole buffer atomically into the committed code bank.
- The committed bank is exposed through a read port: the lock-compare logic sees either the old code or the new one, never a mix.

---
 rtl/code_writer.sv | 175 +++++++++++++++++
 tb/tb_code_writer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_writer.sv
// -----------------------------------------------------------------------------
// code_writer
//
// Write side of the lock's code memory. A programming session of 1..DEPTH
// bytes is streamed in over a valid/ready handshake into a staging buffer.
// When the final byte lands, the whole buffer is copied into the committed
// bank in a single cycle, so the lock-compare logic reading rd_data sees
// either the complete old code or the complete new one, never a mix.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   start       opens a session of len bytes (only honoured in IDLE)
//   len         session byte count, legal range 1..DEPTH
//   abort       cancels an open session while loading
//   wr_valid    wr_data carries a code byte
//   wr_data     code byte
//   wr_ready    a byte is accepted this cycle if wr_valid is also high
//   busy        session open (LOAD or COMMIT)
//   done        one-cycle pulse after the commit
//   err         one-cycle pulse after a start with an illegal len
//   code_valid  committed bank holds a completed code
//   wr_count    bytes accepted in the current session
//   rd_addr     read address into the committed bank
//   rd_data     committed[rd_addr], combinational
// -----------------------------------------------------------------------------
module code_writer #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              abort,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              code_valid,
    output logic [ADDR_W:0]   wr_count,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W:0]   len_q;
    logic [DATA_W-1:0] staging   [DEPTH];
    logic [DATA_W-1:0] committed [DEPTH];

    // Decoded per-cycle actions, all produced by the next-state process.
    logic start_ok;
    logic start_bad;
    logic accept;
    logic cancel;
    logic commit;

    // -------------------------------------------------------------------------
    // Next-state and action decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case leaves one unassigned and infers a latch.
        state_next = state;
        start_ok   = 1'b0;
        start_bad  = 1'b0;
        accept     = 1'b0;
        cancel     = 1'b0;
        commit     = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    if (len != '0 && len <= LEN_MAX) begin
                        start_ok   = 1'b1;
                        state_next = LOAD;
                    end else begin
                        start_bad  = 1'b1;
                    end
                end
            end
            LOAD: begin
                // Abort outranks a byte offered in the same cycle.
                if (abort) begin
                    cancel     = 1'b1;
                    state_next = IDLE;
                end else if (wr_valid) begin
                    accept = 1'b1;
                    if (wr_count + 1'b1 == len_q) begin
                        state_next = COMMIT;
                    end
                end
            end
            COMMIT: begin
                commit     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // wr_ready depends only on registered state and abort, never on wr_valid.
    assign wr_ready = (state == LOAD) && !abort;
    assign busy     = (state != IDLE);
    assign rd_data  = committed[rd_addr];

    // -------------------------------------------------------------------------
    // State, counters and both code banks
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state is assigned with <= so every register
            // samples the pre-edge values, independent of statement order.
            state      <= IDLE;
            len_q      <= '0;
            wr_count   <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            code_valid <= 1'b0;
            // NOTE: both banks are cleared on reset because a reset must leave
            // no stale code readable; this keeps them out of plain RAM macros.
            for (int i = 0; i < DEPTH; i++) begin
                staging[i]   <= '0;
                committed[i] <= '0;
            end
        end else begin
            state <= state_next;
            done  <= commit;
            err   <= start_bad;

            if (start_ok) begin
                len_q      <= len;
                wr_count   <= '0;
                code_valid <= 1'b0;
            end

            if (accept) begin
                staging[wr_count[ADDR_W-1:0]] <= wr_data;
                wr_count                      <= wr_count + 1'b1;
            end

            if (cancel) begin
                wr_count <= '0;
            end

            // Whole-bank copy in one cycle; entries past len are zeroed so no
            // tail of an older, longer code survives.
            if (commit) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if ((ADDR_W + 1)'(i) < len_q) begin
                        committed[i] <= staging[i];
                    end else begin
                        committed[i] <= '0;
                    end
                end
                code_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_code_writer.sv
// -----------------------------------------------------------------------------
// tb_code_writer
//
// Directed bench for code_writer. Inputs change 1 time unit after a rising
// edge; outputs are checked in that same window, well before the next edge.
// -----------------------------------------------------------------------------
module tb_code_writer;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W:0]   len = '0;
    logic              abort = 1'b0;
    logic              wr_valid = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_ready;
    logic              busy;
    logic              done;
    logic              err;
    logic              code_valid;
    logic [ADDR_W:0]   wr_count;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [DATA_W-1:0] rd_data;

    int total = 0;
    int bad   = 0;

    code_writer #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .abort     (abort),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .code_valid(code_valid),
        .wr_count  (wr_count),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    always #50 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rd(input string tag, input int addr, input logic [7:0] exp);
        rd_addr = ADDR_W'(addr);
        #1;
        check($sformatf("%s[%0d]", tag, addr), 32'(rd_data), 32'(exp));
    endtask

    task automatic check_idle(input string tag, input logic exp_cv);
        check({tag, "_busy"},     32'(busy),       32'd0);
        check({tag, "_wr_ready"}, 32'(wr_ready),   32'd0);
        check({tag, "_cv"},       32'(code_valid), 32'(exp_cv));
    endtask

    // Full session of n bytes, byte i = base + i, optional bubble between
    // bytes. done must stay low throughout and pulse exactly once at the end.
    task automatic run_session(input int n, input logic [7:0] base, input bit gaps);
        len   = (ADDR_W + 1)'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("sess_busy", 32'(busy), 32'd1);
        check("sess_cv_cleared", 32'(code_valid), 32'd0);
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(base + 8'(i));
            check("sess_ready", 32'(wr_ready), 32'd1);
            tick();
            check("sess_done_low", 32'(done), 32'd0);
            if (gaps && i != n - 1) begin
                wr_valid = 1'b0;
                tick();
                check("sess_gap_done_low", 32'(done), 32'd0);
                check("sess_gap_count", 32'(wr_count), 32'(i + 1));
            end
        end
        wr_valid = 1'b0;
        // Now in COMMIT.
        check("commit_ready", 32'(wr_ready), 32'd0);
        check("commit_busy", 32'(busy), 32'd1);
        check("commit_count", 32'(wr_count), 32'(n));
        tick();
        check("done_pulse", 32'(done), 32'd1);
        check("done_cv", 32'(code_valid), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        // ---------------- reset state ----------------
        tick();
        tick();
        rst = 1'b0;
        check_idle("rst", 1'b0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_count", 32'(wr_count), 32'd0);
        for (int a = 0; a < DEPTH; a++) check_rd("rst_rd", a, 8'h00);

        // ---------------- len=4, no gaps ----------------
        len   = 5'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            case (i)
                0: wr_data = 8'hA1;
                1: wr_data = 8'hB2;
                2: wr_data = 8'hC3;
                default: wr_data = 8'hD4;
            endcase
            check("l4_ready", 32'(wr_ready), 32'd1);
            tick();
        end
        wr_valid = 1'b0;
        check("l4_commit_ready", 32'(wr_ready), 32'd0);
        check("l4_commit_done", 32'(done), 32'd0);
        check_rd("l4_before_commit", 0, 8'h00);
        tick();
        check("l4_done", 32'(done), 32'd1);
        check("l4_cv", 32'(code_valid), 32'd1);
        check_rd("l4_rd", 0, 8'hA1);
        check_rd("l4_rd", 1, 8'hB2);
        check_rd("l4_rd", 2, 8'hC3);
        check_rd("l4_rd", 3, 8'hD4);
        for (int a = 4; a < DEPTH; a++) check_rd("l4_rd", a, 8'h00);
        tick();
        check("l4_done_drop", 32'(done), 32'd0);
        check("l4_cv_hold", 32'(code_valid), 32'd1);

        // ---------------- len=16 with bubbles; staging hidden ----------------
        len   = 5'd16;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'h10 + 8'(i));
            tick();
        end
        wr_valid = 1'b0;
        check_rd("l16_staging_hidden", 0, 8'hA1);
        check_rd("l16_staging_hidden", 4, 8'h00);
        // Abandon via reset-free path: finish this session with run_session
        // on a fresh start would be ignored in LOAD, so send the rest here.
        for (int i = 5; i < 16; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'h10 + 8'(i));
            tick();
            check("l16_done_low", 32'(done), 32'd0);
            if (i != 15) begin
                wr_valid = 1'b0;
                tick();
                check("l16_gap_done_low", 32'(done), 32'd0);
            end
        end
        wr_valid = 1'b0;
        check("l16_count", 32'(wr_count), 32'd16);
        tick();
        check("l16_done", 32'(done), 32'd1);
        tick();
        check("l16_done_once", 32'(done), 32'd0);
        check_rd("l16_rd", 0, 8'h10);
        check_rd("l16_rd", 7, 8'h17);
        check_rd("l16_rd", 15, 8'h1F);

        // ---------------- illegal len: 0 then 17 ----------------
        len   = 5'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("len0_err", 32'(err), 32'd1);
        check_idle("len0", 1'b1);
        tick();
        check("len0_err_drop", 32'(err), 32'd0);
        len   = 5'd17;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("len17_err", 32'(err), 32'd1);
        check_idle("len17", 1'b1);
        tick();
        check("len17_err_drop", 32'(err), 32'd0);
        check_rd("err_bank", 15, 8'h1F);

        // ---------------- commit 11..13, then abort a new session ----------------
        run_session(3, 8'h11, 1'b1);
        check_rd("pre_abort", 3, 8'h00);
        // Back-to-back: start in the cycle right after done.
        len   = 5'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        wr_valid = 1'b1;
        wr_data  = 8'h55;
        tick();
        check_rd("abort_hold_a", 0, 8'h11);
        wr_data = 8'h66;
        tick();
        check("abort_count2", 32'(wr_count), 32'd2);
        wr_data = 8'h77;
        abort   = 1'b1;
        #1;
        check("abort_ready", 32'(wr_ready), 32'd0);
        tick();
        abort    = 1'b0;
        wr_valid = 1'b0;
        check_idle("abort", 1'b0);
        check("abort_count_clr", 32'(wr_count), 32'd0);
        check("abort_no_done", 32'(done), 32'd0);
        check_rd("abort_rd", 0, 8'h11);
        check_rd("abort_rd", 1, 8'h12);
        check_rd("abort_rd", 2, 8'h13);
        tick();
        check("abort_stays_idle", 32'(busy), 32'd0);

        // ---------------- reset mid-LOAD ----------------
        len   = 5'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 8'h31;
        tick();
        wr_data = 8'h32;
        tick();
        wr_data = 8'h33;
        rst     = 1'b1;
        tick();
        rst      = 1'b0;
        wr_valid = 1'b0;
        check_idle("mid_rst", 1'b0);
        check("mid_rst_count", 32'(wr_count), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        for (int a = 0; a < DEPTH; a++) check_rd("mid_rst_rd", a, 8'h00);

        // ---------------- normal session after reset ----------------
        run_session(2, 8'hE0, 1'b0);
        check_rd("post_rst", 0, 8'hE0);
        check_rd("post_rst", 1, 8'hE1);
        check_rd("post_rst", 2, 8'h00);
        tick();
        check("post_rst_done_drop", 32'(done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
